// File: rtl/point_cache_loader.sv
// point_cache_loader
// Packs a stream of LiDAR points (x, y, z) into wide per-slot cache vectors,
// one slot per distance module, and hands each completed (full or in_last
// terminated) batch to the feeder side with a valid/ack handshake.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       point stream handshake
//   in_x/in_y/in_z          point coordinates (N bits each)
//   in_last                 final point of a batch (qualified by in_valid)
//   cache_x/cache_y/cache_z packed slot vectors, slot k at [k*N +: N]
//   cache_count             number of valid slots in the presented batch
//   cache_valid/cache_ack   batch presentation handshake
//   batch_cnt               completed-batch counter (wraps)
module point_cache_loader #(
    parameter int unsigned N                 = 16,
    parameter int unsigned DISNTANCE_MODULES = 32,
    parameter int unsigned CW                = $clog2(DISNTANCE_MODULES) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_x,
    input  logic [N-1:0]                   in_y,
    input  logic [N-1:0]                   in_z,
    input  logic                           in_last,
    output logic [N*DISNTANCE_MODULES-1:0] cache_x,
    output logic [N*DISNTANCE_MODULES-1:0] cache_y,
    output logic [N*DISNTANCE_MODULES-1:0] cache_z,
    output logic [CW-1:0]                  cache_count,
    output logic                           cache_valid,
    input  logic                           cache_ack,
    output logic [15:0]                    batch_cnt
);

    localparam int unsigned IW      = $clog2(DISNTANCE_MODULES);
    localparam int unsigned CACHE_W = N * DISNTANCE_MODULES;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q,       state_d;
    logic [IW-1:0]        wr_idx_q,      wr_idx_d;
    logic [CACHE_W-1:0]   cache_x_q,     cache_x_d;
    logic [CACHE_W-1:0]   cache_y_q,     cache_y_d;
    logic [CACHE_W-1:0]   cache_z_q,     cache_z_d;
    logic [CW-1:0]        cache_count_q, cache_count_d;
    logic                 cache_valid_q, cache_valid_d;
    logic [15:0]          batch_cnt_q,   batch_cnt_d;
    logic                 batch_close;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            cache_x_q     <= '0;
            cache_y_q     <= '0;
            cache_z_q     <= '0;
            cache_count_q <= '0;
            cache_valid_q <= 1'b0;
            batch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            cache_x_q     <= cache_x_d;
            cache_y_q     <= cache_y_d;
            cache_z_q     <= cache_z_d;
            cache_count_q <= cache_count_d;
            cache_valid_q <= cache_valid_d;
            batch_cnt_q   <= batch_cnt_d;
        end
    end

    // Next-state: fill slots in FILL, freeze in HOLD until acked
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        cache_x_d     = cache_x_q;
        cache_y_d     = cache_y_q;
        cache_z_d     = cache_z_q;
        cache_count_d = cache_count_q;
        cache_valid_d = cache_valid_q;
        batch_cnt_d   = batch_cnt_q;
        batch_close   = 1'b0;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    cache_x_d[32'(wr_idx_q) * N +: N] = in_x;
                    cache_y_d[32'(wr_idx_q) * N +: N] = in_y;
                    cache_z_d[32'(wr_idx_q) * N +: N] = in_z;
                    batch_close = in_last ||
                                  (wr_idx_q == IW'(DISNTANCE_MODULES - 1));
                    if (batch_close) begin
                        state_d       = HOLD;
                        cache_valid_d = 1'b1;
                        cache_count_d = CW'(wr_idx_q) + CW'(1);
                        batch_cnt_d   = batch_cnt_q + 16'd1;
                        wr_idx_d      = '0;
                    end else begin
                        wr_idx_d      = wr_idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                // Clearing all slots here keeps unused slots of a later
                // partial batch at zero without a per-slot valid mask.
                if (cache_ack) begin
                    state_d       = FILL;
                    cache_valid_d = 1'b0;
                    cache_count_d = '0;
                    cache_x_d     = '0;
                    cache_y_d     = '0;
                    cache_z_d     = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign in_ready    = (state_q == FILL);
    assign cache_x     = cache_x_q;
    assign cache_y     = cache_y_q;
    assign cache_z     = cache_z_q;
    assign cache_count = cache_count_q;
    assign cache_valid = cache_valid_q;
    assign batch_cnt   = batch_cnt_q;

endmodule

// File: tb/tb_point_cache_loader.sv
// Testbench for point_cache_loader: table-driven vectors, directed corner
// sequences and randomized traffic, all checked every cycle against a
// queue-based batch model.
module tb_point_cache_loader;

    localparam int unsigned N  = 16;
    localparam int unsigned DM = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned VW = N * DM;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x, in_y, in_z;
    logic          in_last;
    logic [VW-1:0] cache_x, cache_y, cache_z;
    logic [CW-1:0] cache_count;
    logic          cache_valid;
    logic          cache_ack;
    logic [15:0]   batch_cnt;

    int checks;
    int failures;

    point_cache_loader #(.N(N), .DISNTANCE_MODULES(DM), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .in_last     (in_last),
        .cache_x     (cache_x),
        .cache_y     (cache_y),
        .cache_z     (cache_z),
        .cache_count (cache_count),
        .cache_valid (cache_valid),
        .cache_ack   (cache_ack),
        .batch_cnt   (batch_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: points collected into a pending queue; a closed batch
    // moves to the presented queue until acknowledged.
    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
    } pt_t;

    pt_t pend[$];
    pt_t pres[$];
    bit  m_hold;
    int  m_count;
    int  m_batch;

    task automatic chk(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance model and DUT by one edge, then compare every output.
    task automatic tick();
        logic [VW-1:0] ex, ey, ez;
        int            n;
        pt_t           p;
        if (reset) begin
            pend.delete();
            pres.delete();
            m_hold  = 1'b0;
            m_count = 0;
            m_batch = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                p.x = in_x; p.y = in_y; p.z = in_z;
                pend.push_back(p);
                if (pend.size() == DM || in_last) begin
                    pres = pend;
                    pend.delete();
                    m_hold  = 1'b1;
                    m_count = pres.size();
                    m_batch = (m_batch + 1) % 65536;
                end
            end
        end else if (cache_ack) begin
            m_hold = 1'b0;
            pres.delete();
            m_count = 0;
        end
        @(posedge clock);
        #1;
        ex = '0; ey = '0; ez = '0;
        n = m_hold ? pres.size() : pend.size();
        for (int i = 0; i < n; i++) begin
            p = m_hold ? pres[i] : pend[i];
            ex[i*N +: N] = p.x;
            ey[i*N +: N] = p.y;
            ez[i*N +: N] = p.z;
        end
        chk("in_ready",    VW'(in_ready),    VW'(!m_hold));
        chk("cache_valid", VW'(cache_valid), VW'(m_hold));
        chk("cache_count", VW'(cache_count), VW'(m_count));
        chk("batch_cnt",   VW'(batch_cnt),   VW'(m_batch));
        chk("cache_x", cache_x, ex);
        chk("cache_y", cache_y, ey);
        chk("cache_z", cache_z, ez);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_last = 1'b0; cache_ack = 1'b0;
        in_x = '0; in_y = '0; in_z = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] z, input logic last);
        in_valid = 1'b1; in_last = last; in_x = x; in_y = y; in_z = z;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    typedef struct {
        logic         v;
        logic         l;
        logic         ack;
        logic [N-1:0] x;
        logic         e_ready;
        logic         e_valid;
        int           e_count;
        int           e_batch;
        logic [N-1:0] e_x0;
        logic [N-1:0] e_x1;
    } vec_t;

    vec_t vecs[7];
    logic [N-1:0] first_x;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        m_hold = 1'b0; m_count = 0; m_batch = 0;
        tick();
        reset = 1'b0;
        chk("reset_in_ready", VW'(in_ready), VW'(1'b1));

        // Table: short batch, stray ack/last, hold, ack, 1-point batch
        vecs[0] = '{1, 0, 0, 16'h0001, 1, 0, 0, 0, 16'h0001, 16'h0000};
        vecs[1] = '{0, 1, 1, 16'h0000, 1, 0, 0, 0, 16'h0001, 16'h0000};
        vecs[2] = '{1, 1, 0, 16'h0002, 0, 1, 2, 1, 16'h0001, 16'h0002};
        vecs[3] = '{1, 0, 0, 16'hBEEF, 0, 1, 2, 1, 16'h0001, 16'h0002};
        vecs[4] = '{0, 0, 1, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000};
        vecs[5] = '{1, 1, 0, 16'h0003, 0, 1, 1, 2, 16'h0003, 16'h0000};
        vecs[6] = '{0, 0, 1, 16'h0000, 1, 0, 0, 2, 16'h0000, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].v; in_last = vecs[i].l; cache_ack = vecs[i].ack;
            in_x = vecs[i].x; in_y = vecs[i].x; in_z = vecs[i].x;
            tick();
            chk("tbl_ready", VW'(in_ready),      VW'(vecs[i].e_ready));
            chk("tbl_valid", VW'(cache_valid),   VW'(vecs[i].e_valid));
            chk("tbl_count", VW'(cache_count),   VW'(vecs[i].e_count));
            chk("tbl_batch", VW'(batch_cnt),     VW'(vecs[i].e_batch));
            chk("tbl_x0",    VW'(cache_x[0 +: N]), VW'(vecs[i].e_x0));
            chk("tbl_x1",    VW'(cache_x[N +: N]), VW'(vecs[i].e_x1));
        end
        idle_inputs();

        // Full batch, back to back
        do_reset();
        for (int k = 0; k < 32; k++) send(N'(k), N'(100 + k), N'(200 + k), 1'b0);
        chk("full_valid", VW'(cache_valid), VW'(1));
        chk("full_count", VW'(cache_count), VW'(32));
        chk("full_x31",   VW'(cache_x[31*N +: N]), VW'(31));
        chk("full_z31",   VW'(cache_z[31*N +: N]), VW'(231));
        chk("full_batch", VW'(batch_cnt),   VW'(1));
        chk("full_ready", VW'(in_ready),    VW'(0));

        // Partial batch then hold under input pressure, then ack
        do_reset();
        for (int k = 0; k < 5; k++) send(N'(k + 1), N'(100 + k), N'(200 + k), k == 4);
        chk("part_count", VW'(cache_count), VW'(5));
        chk("part_y4",    VW'(cache_y[4*N +: N]), VW'(104));
        chk("part_x5",    VW'(cache_x[5*N +: N]), VW'(0));
        chk("part_batch", VW'(batch_cnt), VW'(1));
        in_valid = 1'b1; in_x = 16'hBEEF; in_y = 16'hBEEF; in_z = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_valid", VW'(cache_valid), VW'(1));
            chk("hold_x0",    VW'(cache_x[0 +: N]), VW'(1));
        end
        in_valid = 1'b0;
        cache_ack = 1'b1;
        tick();
        cache_ack = 1'b0;
        chk("ack_valid", VW'(cache_valid), VW'(0));
        chk("ack_zero",  cache_x | cache_y | cache_z, VW'(0));
        chk("ack_ready", VW'(in_ready), VW'(1));
        send(16'h0042, 16'h0043, 16'h0044, 1'b0);
        chk("next_slot0", VW'(cache_x[0 +: N]), VW'(16'h0042));

        // Gapped input: valid every other cycle, 32nd point on cycle 63
        do_reset();
        for (int c = 0; c < 63; c++) begin
            in_valid = (c % 2 == 0);
            in_x = N'(c / 2); in_y = N'(100 + c / 2); in_z = N'(200 + c / 2);
            tick();
            if (c == 61) chk("gap_not_yet", VW'(cache_valid), VW'(0));
        end
        in_valid = 1'b0;
        chk("gap_valid", VW'(cache_valid), VW'(1));
        chk("gap_count", VW'(cache_count), VW'(32));
        chk("gap_x31",   VW'(cache_x[31*N +: N]), VW'(31));

        // Reset mid-fill drops partial batch
        do_reset();
        for (int k = 0; k < 10; k++) send(N'(50 + k), N'(k), N'(k), 1'b0);
        do_reset();
        first_x = 16'h0777;
        send(first_x, 16'h1, 16'h2, 1'b0);
        send(16'h0778, 16'h3, 16'h4, 1'b0);
        send(16'h0779, 16'h5, 16'h6, 1'b1);
        chk("rst_count", VW'(cache_count), VW'(3));
        chk("rst_slot0", VW'(cache_x[0 +: N]), VW'(first_x));
        chk("rst_batch", VW'(batch_cnt), VW'(1));
        chk("rst_slot3", VW'(cache_x[3*N +: N]), VW'(0));

        // Stray ack and unqualified last during FILL
        do_reset();
        for (int k = 0; k < 4; k++) send(N'(k + 10), N'(k), N'(k), 1'b0);
        in_valid = 1'b0; in_last = 1'b1; cache_ack = 1'b1;
        tick();
        idle_inputs();
        chk("stray_valid", VW'(cache_valid), VW'(0));
        send(16'h0ABC, 16'h0, 16'h0, 1'b0);
        chk("stray_slot4", VW'(cache_x[4*N +: N]), VW'(16'h0ABC));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 15) == 0);
            cache_ack = ($urandom_range(0, 3) == 0);
            in_x = N'($urandom); in_y = N'($urandom); in_z = N'($urandom);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
